// File: rtl/rcv_timing_ctrl_pkg.sv
// Shared types and constants for the serial receive timing controller.
package rcv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } rcv_state_t;

  // Shortest usable bit period; anything below is promoted to this.
  localparam int MIN_CPB = 2;

endpackage

// File: rtl/rcv_timing_ctrl_if.sv
// Control/status bundle between the start-bit detector side and the timing controller.
interface rcv_timing_ctrl_if #(
  parameter int CNT_BITS = 10,
  parameter int DSZ      = 4
);

  logic                start_bit_detected;
  logic                serial_in;
  logic                abort;
  logic [CNT_BITS-1:0] clks_per_bit;
  logic [DSZ-1:0]      data_size;
  logic                busy;
  logic                shift_strobe;
  logic                load_buffer;
  logic                packet_done;
  logic                framing_error;

  // Upstream side: drives line, start pulse and frame configuration.
  modport master (
    output start_bit_detected, serial_in, abort, clks_per_bit, data_size,
    input  busy, shift_strobe, load_buffer, packet_done, framing_error
  );

  // Controller side.
  modport slave (
    input  start_bit_detected, serial_in, abort, clks_per_bit, data_size,
    output busy, shift_strobe, load_buffer, packet_done, framing_error
  );

endinterface

// File: rtl/rcv_tick_counter.sv
// Bit-period pacing counter: counts up from 0 after a clear, ticks when the
// count equals limit, then restarts at 1 so ticks repeat every limit cycles.
module rcv_tick_counter #(
  parameter int CNT_BITS = 10
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                enable,
  input  logic [CNT_BITS-1:0] limit,
  output logic [CNT_BITS-1:0] count,
  output logic                tick
);

  logic [CNT_BITS-1:0] count_reg;

  assign count = count_reg;
  assign tick  = enable && (count_reg == limit);

  // Rollover counter; a clear always wins so every state entry starts from 0.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= tick ? CNT_BITS'(1) : count_reg + CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/rcv_timing_ctrl.sv
// Receive sequencing controller: paces bit periods, checks start/stop bits,
// strobes each data bit and signals frame completion or framing error.
module rcv_timing_ctrl
  import rcv_pkg::*;
#(
  parameter int CNT_BITS = 10,
  parameter int MAX_DATA = 8
) (
  input logic              clk,
  input logic              n_rst,
  rcv_timing_ctrl_if.slave bus
);

  localparam int DSZ = $clog2(MAX_DATA + 1);
  localparam int BCW = $clog2(MAX_DATA) + 1;

  rcv_state_t          state_reg, state_next;
  logic [CNT_BITS-1:0] cpb_reg, cpb_in, limit, count;
  logic [DSZ-1:0]      dsz_reg, dsz_in;
  logic [BCW-1:0]      bit_cnt_reg;
  logic                fe_reg;
  logic                tick, accept, last_bit, cnt_clear, cnt_enable;

  // Normalise the requested frame shape before it is latched.
  assign cpb_in = (bus.clks_per_bit < CNT_BITS'(MIN_CPB)) ? CNT_BITS'(MIN_CPB) : bus.clks_per_bit;
  assign dsz_in = ((bus.data_size == '0) || (int'(bus.data_size) > MAX_DATA)) ?
                  DSZ'(MAX_DATA) : bus.data_size;

  assign accept     = (state_reg == IDLE) && bus.start_bit_detected && !bus.abort;
  assign last_bit   = (int'(bit_cnt_reg) == int'(dsz_reg) - 1);
  // Start bit is checked mid-period; data and stop bits one full period apart.
  assign limit      = (state_reg == START) ? (cpb_reg >> 1) : cpb_reg;
  assign cnt_enable = (state_reg != IDLE);
  assign cnt_clear  = (state_reg == IDLE) || (state_next != state_reg);

  rcv_tick_counter #(
    .CNT_BITS (CNT_BITS)
  ) u_tick (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .limit  (limit),
    .count  (count),
    .tick   (tick)
  );

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start_bit_detected) state_next = START;
      START:   if (tick) state_next = bus.serial_in ? IDLE : DATA;
      DATA:    if (tick && last_bit) state_next = STOP;
      STOP:    if (tick) state_next = bus.serial_in ? DONE : IDLE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.abort) state_next = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Frame configuration is captured once per accepted start.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cpb_reg <= '0;
      dsz_reg <= '0;
    end else if (accept) begin
      cpb_reg <= cpb_in;
      dsz_reg <= dsz_in;
    end
  end

  // Data bit counter, restarted for every accepted frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt_reg <= '0;
    end else if (accept) begin
      bit_cnt_reg <= '0;
    end else if ((state_reg == DATA) && tick && !bus.abort) begin
      bit_cnt_reg <= bit_cnt_reg + BCW'(1);
    end
  end

  // Sticky framing error: set by a low stop bit, cleared by the next accepted start.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fe_reg <= 1'b0;
    end else if (accept) begin
      fe_reg <= 1'b0;
    end else if ((state_reg == STOP) && tick && !bus.serial_in && !bus.abort) begin
      fe_reg <= 1'b1;
    end
  end

  // Outputs decoded from state and count; an abort cycle emits no strobe or load.
  assign bus.busy          = (state_reg != IDLE);
  assign bus.shift_strobe  = (state_reg == DATA) && (count == cpb_reg) && !bus.abort;
  assign bus.load_buffer   = (state_reg == DONE) && !bus.abort;
  assign bus.packet_done   = (state_reg == DONE) && !bus.abort;
  assign bus.framing_error = fe_reg;

endmodule

// File: tb/tb_rcv_timing_ctrl.sv
// Self-checking bench for rcv_timing_ctrl: directed frame table, hand-written
// reset sequences and randomized frames against a frame-level timing model.
module tb_rcv_timing_ctrl;

  localparam int CNT_BITS = 10;
  localparam int MAX_DATA = 8;
  localparam int DSZ      = $clog2(MAX_DATA + 1);
  localparam int MAXL     = 512;
  localparam int NVEC     = 13;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  rcv_timing_ctrl_if #(.CNT_BITS(CNT_BITS), .DSZ(DSZ)) bus ();

  rcv_timing_ctrl #(
    .CNT_BITS (CNT_BITS),
    .MAX_DATA (MAX_DATA)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // mode: 0 good frame, 1 false start, 2 low stop bit, 3 raw waveform
  typedef struct {
    int cpb; int dsz; int data; int mode;
    int abort_at; int ex1; int ex2; int chg_at;
    int nstr; int first; int spacing; int load; int fe_rise; int bend;
  } vec_t;

  vec_t vecs [NVEC];

  int   checks = 0;
  int   errors = 0;
  int   prev_fe = 0;
  logic line_v [MAXL];

  // expected frame results
  int e_strobes [16];
  int e_nstr, e_load, e_fe_rise, e_end;
  // observed frame results
  int o_strobes [16];
  int o_nstr, o_load, o_nload, o_pd_bad, o_fe0, o_fe1, o_busy1, o_fe_rise, o_end, o_fe_final;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int eff_cpb(input int cpb);
    return (cpb < 2) ? 2 : cpb;
  endfunction

  function automatic int eff_dsz(input int dsz);
    return (dsz == 0 || dsz > MAX_DATA) ? MAX_DATA : dsz;
  endfunction

  // UART-style line: start bit, data LSB first, stop bit, idle high.
  task automatic build_line(input int cpb, input int dsz, input int data, input int mode);
    int cp, ds, st, sp;
    cp = eff_cpb(cpb);
    ds = eff_dsz(dsz);
    for (int i = 0; i < MAXL; i++) line_v[i] = 1'b1;
    for (int i = 0; i < cp; i++) line_v[i] = 1'b0;
    for (int b = 0; b < ds; b++)
      for (int j = 0; j < cp; j++) line_v[cp * (b + 1) + j] = ((data >> b) & 1) != 0;
    st = cp / 2 + 1;
    sp = cp / 2 + 3 + cp * (ds + 1);
    if (mode == 1) begin
      line_v[st] = 1'b1;
    end else if (mode == 0 || mode == 2) begin
      line_v[st] = 1'b0;
      line_v[sp] = (mode == 0);
    end
  endtask

  // Frame-level expectation: sample instants follow from the bit period arithmetic.
  task automatic model(input int cpb, input int dsz, input int abort_at);
    int cp, ds, t, e, s, stop_t;
    cp = eff_cpb(cpb);
    ds = eff_dsz(dsz);
    e_nstr = 0; e_load = -1; e_fe_rise = -1;
    t = cp / 2 + 1;
    if (abort_at >= 1 && abort_at <= t) begin e_end = abort_at + 1; return; end
    if (line_v[t]) begin e_end = t + 1; return; end
    e = t + 1;
    for (int i = 1; i <= ds; i++) begin
      s = e + cp * i;
      if (abort_at >= 1 && abort_at <= s) begin e_end = abort_at + 1; return; end
      e_strobes[e_nstr] = s;
      e_nstr = e_nstr + 1;
    end
    stop_t = e + cp * ds + 1 + cp;
    if (abort_at >= 1 && abort_at <= stop_t) begin e_end = abort_at + 1; return; end
    if (!line_v[stop_t]) begin e_fe_rise = stop_t + 1; e_end = stop_t + 1; return; end
    e_end = stop_t + 2;
    if (abort_at != stop_t + 1) e_load = stop_t + 1;
  endtask

  // Drive one frame (start pulse in cycle 0) and record what the DUT does.
  task automatic run_frame(input int cpb, input int dsz, input int abort_at,
                           input int ex1, input int ex2, input int chg_at, input int len);
    o_nstr = 0; o_load = -1; o_nload = 0; o_pd_bad = 0; o_fe0 = -1; o_fe1 = -1;
    o_busy1 = -1; o_fe_rise = -1; o_end = -1; o_fe_final = -1;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      bus.start_bit_detected = (k == 0) || (k == ex1) || (k == ex2);
      bus.serial_in          = line_v[k];
      bus.abort              = (k == abort_at);
      if (k == 0) begin
        bus.clks_per_bit = CNT_BITS'(cpb);
        bus.data_size    = DSZ'(dsz);
      end
      if (k == chg_at) begin
        bus.clks_per_bit = CNT_BITS'(20);
        bus.data_size    = DSZ'(3);
      end
      #1;
      if (bus.shift_strobe) begin
        if (o_nstr < 16) o_strobes[o_nstr] = k;
        o_nstr++;
      end
      if (bus.load_buffer) begin
        if (o_nload == 0) o_load = k;
        o_nload++;
      end
      if (bus.load_buffer != bus.packet_done) o_pd_bad++;
      if (k == 0) o_fe0 = int'(bus.framing_error);
      if (k == 1) begin
        o_fe1   = int'(bus.framing_error);
        o_busy1 = int'(bus.busy);
      end
      if (k >= 1 && !bus.busy && o_end < 0) o_end = k;
      if (k >= 1 && bus.framing_error && o_fe_rise < 0) o_fe_rise = k;
      o_fe_final = int'(bus.framing_error);
    end
  endtask

  task automatic check_frame(input string tag);
    check({tag, " busy@1"}, o_busy1, 1);
    check({tag, " fe@0"}, o_fe0, prev_fe);
    check({tag, " fe@1"}, o_fe1, 0);
    check({tag, " n_strobes"}, o_nstr, e_nstr);
    for (int i = 0; i < e_nstr; i++)
      check($sformatf("%s strobe%0d", tag, i), (i < o_nstr && i < 16) ? o_strobes[i] : -1, e_strobes[i]);
    check({tag, " load_cycle"}, o_load, e_load);
    check({tag, " n_loads"}, o_nload, (e_load >= 0) ? 1 : 0);
    check({tag, " pd_vs_load"}, o_pd_bad, 0);
    check({tag, " fe_rise"}, o_fe_rise, e_fe_rise);
    check({tag, " fe_final"}, o_fe_final, (e_fe_rise >= 0) ? 1 : 0);
    check({tag, " idle_cycle"}, o_end, e_end);
    prev_fe = (e_fe_rise >= 0) ? 1 : 0;
    $display("frame %s strobes=%0d load=%0d fe=%0d idle@%0d", tag, o_nstr, o_load, o_fe_final, o_end);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    build_line(v.cpb, v.dsz, v.data, v.mode);
    e_nstr = v.nstr;
    for (int j = 0; j < v.nstr; j++) e_strobes[j] = v.first + v.spacing * j;
    e_load = v.load; e_fe_rise = v.fe_rise; e_end = v.bend;
    run_frame(v.cpb, v.dsz, v.abort_at, v.ex1, v.ex2, v.chg_at, v.bend + 4);
    check_frame($sformatf("vec%0d", i));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, int'(bus.busy), 0);
    check({tag, " shift_strobe"}, int'(bus.shift_strobe), 0);
    check({tag, " load_buffer"}, int'(bus.load_buffer), 0);
    check({tag, " packet_done"}, int'(bus.packet_done), 0);
    check({tag, " framing_error"}, int'(bus.framing_error), 0);
  endtask

  initial begin
    //          cpb dsz data mode abrt ex1 ex2 chg  nstr first sp load fe_rise end
    vecs[0]  = '{10, 8, 165, 0, -1, -1, -1, -1,  8, 17, 10,  99, -1, 100};
    vecs[1]  = '{10, 8, 165, 1, -1, -1, -1, -1,  0, -1,  0,  -1, -1,   7};
    vecs[2]  = '{10, 8, 165, 2, -1, -1, -1, -1,  8, 17, 10,  -1, 99,  99};
    vecs[3]  = '{ 1, 0, 165, 0, -1, -1, -1,  5,  8,  5,  2,  23, -1,  24};
    vecs[4]  = '{10, 8, 165, 0, 40, -1, -1, -1,  3, 17, 10,  -1, -1,  41};
    vecs[5]  = '{10, 8, 165, 0, -1, 30, 55, -1,  8, 17, 10,  99, -1, 100};
    vecs[6]  = '{ 3, 5,  90, 0, -1, -1, -1, -1,  5,  6,  3,  23, -1,  24};
    vecs[7]  = '{ 4,12, 200, 0, -1, -1, -1, -1,  8,  8,  4,  42, -1,  43};
    vecs[8]  = '{11, 1,   1, 0, -1, -1, -1, -1,  1, 18, 11,  31, -1,  32};
    vecs[9]  = '{10, 8, 165, 0,  3, -1, -1, -1,  0, -1,  0,  -1, -1,   4};
    vecs[10] = '{ 4, 1,   0, 2, 13, -1, -1, -1,  1,  8,  4,  -1, -1,  14};
    vecs[11] = '{10, 8, 165, 0, 27, -1, -1, -1,  1, 17, 10,  -1, -1,  28};
    vecs[12] = '{ 4, 1,   0, 0, 14, -1, -1, -1,  1,  8,  4,  -1, -1,  15};

    bus.start_bit_detected = 1'b0;
    bus.serial_in          = 1'b1;
    bus.abort              = 1'b0;
    bus.clks_per_bit       = '0;
    bus.data_size          = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Framing error held in idle, then cleared by an asynchronous reset
    run_vec(2);
    @(negedge clk);
    #1;
    check("fe_held_idle", int'(bus.framing_error), 1);
    #1;
    n_rst = 1'b0;
    #1;
    check("fe_async_clear", int'(bus.framing_error), 0);
    @(negedge clk);
    n_rst = 1'b1;
    prev_fe = 0;

    // Reset in the middle of a frame
    build_line(10, 8, 165, 0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      bus.start_bit_detected = (k == 0);
      bus.serial_in          = line_v[k];
      bus.abort              = 1'b0;
      bus.clks_per_bit       = CNT_BITS'(10);
      bus.data_size          = DSZ'(8);
    end
    #1;
    check("midrst pre busy", int'(bus.busy), 1);
    @(negedge clk);
    bus.serial_in = line_v[50];
    #2;
    n_rst = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    run_vec(0);

    // Randomized frames against the model
    for (int r = 0; r < 40; r++) begin
      int cpb, dsz, data, mode, ab, chg;
      cpb  = int'($urandom_range(0, 12));
      dsz  = int'($urandom_range(0, 10));
      data = int'($urandom_range(0, 255));
      mode = int'($urandom_range(0, 3));
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : -1;
      chg  = int'($urandom_range(1, 30));
      build_line(cpb, dsz, data, mode);
      model(cpb, dsz, ab);
      run_frame(cpb, dsz, ab, -1, -1, chg, e_end + 4);
      check_frame($sformatf("rnd%0d cpb=%0d dsz=%0d", r, cpb, dsz));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
